mem_subword_ctrl: RTL and testbench
===================================

# mem_subword_ctrl

Memory access controller between the processor's load/store datapath and the word-only data memory. Converts byte, halfword and word loads and stores into word-granular memory cycles. Sub-word stores use read-modify-write; loads are extracted and sign/zero-extended. Stalls the core through a ready/valid handshake until each access completes.

## Interface
- ADDR_W, 32: address width of `req_addr` and `dm_address`.
- DATA_W, 32: data width; fixed at 32 and not overridable in practice.
- clock  in  1  single clock for the block; all registers update on its rising edge.
- reset  in  1  asynchronous, active-low; `0` forces reset state immediately.
- req_valid  in  1  core presents a request.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_read  in  1  load request.
- req_write  in  1  store request.
- req_size  in  2  SZ_BYTE=00, SZ_HALF=01, SZ_WORD=10; 11 reserved.
- req_signed  in  1  sign-extend on loads; ignored on stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; right-aligned for sub-word sizes.
- resp_valid  out  1  one-cycle pulse: access finished.
- resp_rdata  out  32  extended load result; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: misaligned, reserved size, or read+write both set.
- dm_address  out  32  word address `{req_addr[31:2],2'b00}`.
- dm_readEnable  out  1  memory read strobe.
- dm_writeEnable  out  1  memory write strobe.
- dm_writeInput  out  32  full word to write.
- dm_readResult  in  32  memory read data, registered by the memory; valid the cycle after a read strobe.

## Operation
- Accept on a rising edge with req_valid & req_ready. Capture all request fields. Later input changes are ignored.
- req_valid with neither read nor write: no accept and no response; treated as a bubble.
- States:
  - IDLE: go to ERR on error. Otherwise go to WR for a word store, or RD for a load or sub-word store.
  - RD: dm_readEnable=1. Next state is MRG.
  - MRG: dm_readResult is valid. For a load, register the extracted data and pulse response, then go to IDLE. For a store, register the merged word, then go to WR.
  - WR: dm_writeEnable=1, dm_writeInput=write register. Next state is IDLE with response pulse.
  - ERR: no memory strobes. Next state is IDLE with resp_err=1.
- Errors:
  - half access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - size 11;
  - read and write both set.
- Lanes are little-endian: byte k occupies bits [8k+7:8k] for addr[1:0]=k. A halfword at addr[1]=h occupies bits [16h+15:16h].
- Store merge replaces only the addressed lane(s) with the low byte or halfword of req_wdata. Other bits keep the read value.
- Load extract: take the addressed lane, then sign- or zero-extend it to 32 bits. Word loads pass through unchanged.
- dm_address stays stable from acceptance until return to IDLE. Strobes are 0 in every other state.

## Timing
- Request accepted at edge k. resp_valid is high during the cycle after:
  - load: edge k+2;
  - word store: edge k+1, with the memory write at edge k+1;
  - sub-word store: edge k+3, with the memory write at edge k+3;
  - error: edge k+1.
- req_ready is high in the same cycle as resp_valid, so back-to-back requests are accepted with no dead cycle.
- resp_rdata and resp_err hold until the next response. resp_valid is exactly one cycle wide.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, dm_readEnable=0, dm_writeEnable=0, dm_writeInput=0, dm_address=0.
- Reset mid-operation: strobes drop asynchronously. No write reaches memory unless its edge has already passed. The pending response is discarded.

## Structure
- Shared package mem_pkg: size_t encoding (SZ_BYTE/SZ_HALF/SZ_WORD), state enum (IDLE, RD, MRG, WR, ERR), and an access-error check function reused by the core's exception logic.
- One combinational sub-module, mem_lane_align, holds the lane logic. Inputs: word, addr[1:0], size, signed, store data. Outputs: extracted load value and merged store word.
- The FSM and registers stay in mem_subword_ctrl.

## Test plan
- Word store then word load:
  - store 0xDEADBEEF to 0x10 → write 1 cycle after accept, no read strobe;
  - load 0x10 → resp_rdata 0xDEADBEEF, 2 cycles after accept.
- Byte store into 0x11223344 at 0x20:
  - sb 0xAA at 0x21 → RD, MRG, WR sequence; memory ends as 0x1122AA44;
  - lb at 0x21 → 0xFFFFFFAA; lbu at 0x21 → 0x000000AA.
- Halfword with word 0x8000_7FFF at 0x30:
  - lh at 0x32 → 0xFFFF8000;
  - lhu at 0x30 → 0x00007FFF;
  - sh 0x1234 at 0x32 → 0x12347FFF.
- Errors:
  - lh at 0x31, lw at 0x32, size 11, read+write → resp_err=1 one cycle after accept;
  - no strobes, memory unchanged.
- Back-to-back: sb then lw issued with req_valid held → second request accepted in the first response cycle; load returns the merged word.
- Reset: assert reset low during MRG of an sb → strobes 0 immediately, memory unchanged, req_ready=1, resp_valid=0.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_pkg
// Purpose : Shared types and helpers for the sub-word memory access path.
//           Holds the access-size encoding, the controller state encoding and
//           an access-error check that the core's exception logic also uses.
// Revision: 1.0 - initial release
// ============================================================================
package mem_pkg;

   // Access size as carried on req_size
   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_t;

   // Controller states
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      MRG  = 3'd2,
      WR   = 3'd3,
      ERR  = 3'd4
   } state_t;

   // Returns 1 when the request cannot be carried out: misaligned halfword or
   // word, reserved size, or a request that is both a load and a store.
   function automatic logic access_err(input logic       rd,
                                       input logic       wr,
                                       input size_t      size,
                                       input logic [1:0] addr_lo);
      logic e;
      e = 1'b0;
      case (size)
         SZ_BYTE: e = 1'b0;
         SZ_HALF: e = addr_lo[0];
         SZ_WORD: e = |addr_lo;
         default: e = 1'b1;
      endcase
      if (rd && wr) begin
         e = 1'b1;
      end
      return e;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module  : mem_lane_align
// Purpose : Combinational little-endian lane logic. Extracts and extends the
//           addressed byte/halfword of a memory word for loads, and merges
//           right-aligned store data into the addressed lane(s) for stores.
// Ports   : i_word       - word read from memory
//           i_addr_lo    - byte offset within the word
//           i_size       - access size
//           i_signed     - sign-extend the extracted value
//           i_store_data - right-aligned store data
//           o_load_data  - extended load result
//           o_merged     - word to write back
// Revision: 1.0 - initial release
// ============================================================================
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_addr_lo,
   input  size_t       i_size,
   input  logic        i_signed,
   input  logic [31:0] i_store_data,
   output logic [31:0] o_load_data,
   output logic [31:0] o_merged
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte      = i_word[{i_addr_lo, 3'b000} +: 8];
      w_half      = i_word[{i_addr_lo[1], 4'b0000} +: 16];
      o_load_data = i_word;
      o_merged    = i_word;
      case (i_size)
         SZ_BYTE: begin
            o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
            o_merged[{i_addr_lo, 3'b000} +: 8] = i_store_data[7:0];
         end
         SZ_HALF: begin
            o_load_data = {{16{i_signed & w_half[15]}}, w_half};
            o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_store_data[15:0];
         end
         default: begin
            // Word accesses pass straight through; the reserved size never
            // reaches a memory cycle, so its value here is irrelevant.
            o_load_data = i_word;
            o_merged    = i_store_data;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_subword_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mem_subword_ctrl
// Purpose : Bridges the core's byte/halfword/word load-store requests onto a
//           word-only data memory. Sub-word stores use read-modify-write,
//           loads are extracted and extended, errors respond without any
//           memory cycle. The core is held off by req_ready until done.
// Ports   : clock/reset         - clock, asynchronous active-low reset
//           req_*               - request handshake and fields from the core
//           resp_*              - one-cycle response pulse, data and error
//           dm_*                - word-granular data memory interface
// Revision: 1.0 - initial release
// ============================================================================
module mem_subword_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_read,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] dm_address,
   output logic              dm_readEnable,
   output logic              dm_writeEnable,
   output logic [DATA_W-1:0] dm_writeInput,
   input  logic [DATA_W-1:0] dm_readResult
);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   size_t               size_q, size_d;
   logic                signed_q, signed_d;
   logic                write_q, write_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                resp_valid_q, resp_valid_d;
   logic                resp_err_q, resp_err_d;

   logic                w_accept;
   logic                w_req_err;
   logic [DATA_W-1:0]   w_load_data;
   logic [DATA_W-1:0]   w_merged;

   // A valid request carrying neither read nor write is a bubble: not taken.
   assign w_accept  = (state_q == IDLE) && req_valid && (req_read || req_write);
   assign w_req_err = access_err(req_read, req_write, size_t'(req_size), req_addr[1:0]);

   mem_lane_align u_lane (
      .i_word       (dm_readResult),
      .i_addr_lo    (addr_q[1:0]),
      .i_size       (size_q),
      .i_signed     (signed_q),
      .i_store_data (wdata_q),
      .o_load_data  (w_load_data),
      .o_merged     (w_merged)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      size_d       = size_q;
      signed_d     = signed_q;
      write_d      = write_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      resp_err_d   = resp_err_q;
      resp_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (w_accept) begin
               addr_d   = req_addr;
               size_d   = size_t'(req_size);
               signed_d = req_signed;
               write_d  = req_write;
               wdata_d  = req_wdata;
               if (w_req_err) begin
                  state_d = ERR;
               end else if (req_write && (req_size == SZ_WORD)) begin
                  state_d = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: begin
            state_d = MRG;
         end
         MRG: begin
            if (write_q) begin
               // Merged word replaces the store data so WR drives it out.
               wdata_d = w_merged;
               state_d = WR;
            end else begin
               rdata_d      = w_load_data;
               resp_err_d   = 1'b0;
               resp_valid_d = 1'b1;
               state_d      = IDLE;
            end
         end
         WR: begin
            rdata_d      = '0;
            resp_err_d   = 1'b0;
            resp_valid_d = 1'b1;
            state_d      = IDLE;
         end
         ERR: begin
            rdata_d      = '0;
            resp_err_d   = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         size_q       <= SZ_BYTE;
         signed_q     <= 1'b0;
         write_q      <= 1'b0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         size_q       <= size_d;
         signed_q     <= signed_d;
         write_q      <= write_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Strobes decode straight from the state register so that reset drops
   // them without waiting for a clock edge.
   assign req_ready      = (state_q == IDLE);
   assign dm_readEnable  = (state_q == RD);
   assign dm_writeEnable = (state_q == WR);
   assign dm_writeInput  = wdata_q;
   assign dm_address     = {addr_q[ADDR_W-1:2], 2'b00};
   assign resp_valid     = resp_valid_q;
   assign resp_rdata     = rdata_q;
   assign resp_err       = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_subword_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_subword_ctrl
// Purpose : Directed self-checking bench for mem_subword_ctrl with a small
//           registered-read word memory model attached to the dm_* port.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_subword_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_read = 1'b0;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] dm_address;
   logic        dm_readEnable;
   logic        dm_writeEnable;
   logic [31:0] dm_writeInput;
   logic [31:0] dm_readResult;

   int n_vec  = 0;
   int n_miss = 0;

   // Word memory: read data registered, available the cycle after the strobe
   logic [31:0] mem [0:63];
   logic [31:0] mem_rd = '0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;

   assign dm_readResult = mem_rd;

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (dm_readEnable) begin
         mem_rd <= mem[dm_address[7:2]];
         rd_cnt <= rd_cnt + 1;
      end
      if (dm_writeEnable) begin
         mem[dm_address[7:2]] <= dm_writeInput;
         wr_cnt <= wr_cnt + 1;
      end
   end

   mem_subword_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clock          (clock),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_read       (req_read),
      .req_write      (req_write),
      .req_size       (req_size),
      .req_signed     (req_signed),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_err       (resp_err),
      .dm_address     (dm_address),
      .dm_readEnable  (dm_readEnable),
      .dm_writeEnable (dm_writeEnable),
      .dm_writeInput  (dm_writeInput),
      .dm_readResult  (dm_readResult)
   );

   task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   // Present a request at a falling edge; it is taken at the next rising edge.
   task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] d,
                        input bit hold);
      @(negedge clock);
      req_valid  = 1'b1;
      req_read   = rd;
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = d;
      @(posedge clock);
      #1;
      if (!hold) begin
         req_valid = 1'b0;
         req_read  = 1'b0;
         req_write = 1'b0;
      end
   endtask

   // Latency counts edges after acceptance until the response cycle.
   task automatic wait_resp(input string tag, input int lat, input logic [31:0] exp_d,
                            input logic exp_e, input logic [31:0] exp_a);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!resp_valid && n < 12);
      chk_vec({tag, " latency"}, n - 1, lat);
      chk_vec({tag, " rdata"}, resp_rdata, exp_d);
      chk_vec({tag, " err"}, {31'd0, resp_err}, {31'd0, exp_e});
      chk_vec({tag, " addr"}, dm_address, exp_a);
      chk_vec({tag, " ready"}, {31'd0, req_ready}, 32'd1);
      @(negedge clock);
      chk_vec({tag, " pulse"}, {31'd0, resp_valid}, 32'd0);
   endtask

   task automatic txn(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                      input logic sg, input logic [31:0] a, input logic [31:0] d,
                      input int lat, input logic [31:0] exp_d, input logic exp_e,
                      input int exp_r, input int exp_w);
      int r0;
      int w0;
      r0 = rd_cnt;
      w0 = wr_cnt;
      issue(rd, wr, sz, sg, a, d, 1'b0);
      wait_resp(tag, lat, exp_d, exp_e, {a[31:2], 2'b00});
      chk_vec({tag, " reads"}, rd_cnt - r0, exp_r);
      chk_vec({tag, " writes"}, wr_cnt - w0, exp_w);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  r0;
      int  w0;
      bit  saw_resp;
      bit  saw_busy;

      // Reset state
      #3;
      chk_vec("rst ready",   {31'd0, req_ready},      32'd1);
      chk_vec("rst valid",   {31'd0, resp_valid},     32'd0);
      chk_vec("rst err",     {31'd0, resp_err},       32'd0);
      chk_vec("rst rdata",   resp_rdata,              32'd0);
      chk_vec("rst rden",    {31'd0, dm_readEnable},  32'd0);
      chk_vec("rst wren",    {31'd0, dm_writeEnable}, 32'd0);
      chk_vec("rst wdata",   dm_writeInput,           32'd0);
      chk_vec("rst addr",    dm_address,              32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b1;

      // Word store / word load
      txn("sw 10", 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 1, 32'h0, 0, 0, 1);
      txn("lw 10", 1, 0, 2'b10, 0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 0, 1, 0);

      // Byte store by read-modify-write, then byte loads
      txn("sw 20", 0, 1, 2'b10, 0, 32'h20, 32'h11223344, 1, 32'h0, 0, 0, 1);
      txn("sb 21", 0, 1, 2'b00, 0, 32'h21, 32'hFFFFFFAA, 3, 32'h0, 0, 1, 1);
      txn("lw 20", 1, 0, 2'b10, 0, 32'h20, 32'h0, 2, 32'h1122AA44, 0, 1, 0);
      txn("lb 21", 1, 0, 2'b00, 1, 32'h21, 32'h0, 2, 32'hFFFFFFAA, 0, 1, 0);
      txn("lbu 21", 1, 0, 2'b00, 0, 32'h21, 32'h0, 2, 32'h000000AA, 0, 1, 0);
      txn("lbu 23", 1, 0, 2'b00, 0, 32'h23, 32'h0, 2, 32'h00000011, 0, 1, 0);

      // Halfwords
      txn("sw 30", 0, 1, 2'b10, 0, 32'h30, 32'h80007FFF, 1, 32'h0, 0, 0, 1);
      txn("lh 32", 1, 0, 2'b01, 1, 32'h32, 32'h0, 2, 32'hFFFF8000, 0, 1, 0);
      txn("lhu 30", 1, 0, 2'b01, 0, 32'h30, 32'h0, 2, 32'h00007FFF, 0, 1, 0);
      txn("lh 30", 1, 0, 2'b01, 1, 32'h30, 32'h0, 2, 32'h00007FFF, 0, 1, 0);
      txn("sh 32", 0, 1, 2'b01, 0, 32'h32, 32'hABCD1234, 3, 32'h0, 0, 1, 1);
      txn("lw 30", 1, 0, 2'b10, 0, 32'h30, 32'h0, 2, 32'h12347FFF, 0, 1, 0);

      // Errors: no memory traffic, response one edge after acceptance
      txn("err lh 31", 1, 0, 2'b01, 1, 32'h31, 32'h0, 1, 32'h0, 1, 0, 0);
      txn("err lw 32", 1, 0, 2'b10, 0, 32'h32, 32'h0, 1, 32'h0, 1, 0, 0);
      txn("err sz11",  1, 0, 2'b11, 0, 32'h30, 32'h0, 1, 32'h0, 1, 0, 0);
      txn("err rw",    1, 1, 2'b10, 0, 32'h30, 32'h5555AAAA, 1, 32'h0, 1, 0, 0);
      txn("lw 30 kept", 1, 0, 2'b10, 0, 32'h30, 32'h0, 2, 32'h12347FFF, 0, 1, 0);

      // Bubble: valid with neither read nor write is never taken
      saw_resp = 1'b0;
      saw_busy = 1'b0;
      @(negedge clock);
      req_valid = 1'b1;
      req_read  = 1'b0;
      req_write = 1'b0;
      repeat (3) begin
         @(negedge clock);
         if (resp_valid) saw_resp = 1'b1;
         if (!req_ready) saw_busy = 1'b1;
      end
      req_valid = 1'b0;
      chk_vec("bubble resp",  {31'd0, saw_resp}, 32'd0);
      chk_vec("bubble ready", {31'd0, saw_busy}, 32'd0);

      // Back-to-back: lw held on the bus is taken in the sb response cycle
      txn("sw 40", 0, 1, 2'b10, 0, 32'h40, 32'h01020304, 1, 32'h0, 0, 0, 1);
      r0 = rd_cnt;
      w0 = wr_cnt;
      issue(0, 1, 2'b00, 0, 32'h40, 32'h00000055, 1'b1);
      req_read  = 1'b1;
      req_write = 1'b0;
      req_size  = 2'b10;
      req_wdata = 32'h0;
      wait_resp("b2b sb", 3, 32'h0, 0, 32'h40);
      req_valid = 1'b0;
      req_read  = 1'b0;
      // The lw was taken one edge before the pulse check returned, so one
      // edge of its two-edge latency has already elapsed here.
      wait_resp("b2b lw", 1, 32'h01020355, 0, 32'h40);
      chk_vec("b2b reads",  rd_cnt - r0, 2);
      chk_vec("b2b writes", wr_cnt - w0, 1);

      // Reset asserted during MRG of a byte store
      txn("sw 50", 0, 1, 2'b10, 0, 32'h50, 32'hCAFEF00D, 1, 32'h0, 0, 0, 1);
      w0 = wr_cnt;
      issue(0, 1, 2'b00, 0, 32'h51, 32'h00000077, 1'b0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk_vec("mid rst wren",  {31'd0, dm_writeEnable}, 32'd0);
      chk_vec("mid rst rden",  {31'd0, dm_readEnable},  32'd0);
      chk_vec("mid rst ready", {31'd0, req_ready},      32'd1);
      chk_vec("mid rst valid", {31'd0, resp_valid},     32'd0);
      @(negedge clock);
      reset = 1'b1;
      saw_resp = 1'b0;
      repeat (4) begin
         @(negedge clock);
         if (resp_valid) saw_resp = 1'b1;
      end
      chk_vec("mid rst no resp", {31'd0, saw_resp}, 32'd0);
      chk_vec("mid rst no wr",   wr_cnt - w0, 0);
      txn("lw 50 kept", 1, 0, 2'b10, 0, 32'h50, 32'h0, 2, 32'hCAFEF00D, 0, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
